// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and the transmit-queue dispatch states.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_DONE = 2'd2
    } txq_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_txq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_txq_fifo
//  Description : Byte FIFO with pointers, occupancy count and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_txq_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   tx_clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]        count,
    output logic                   empty,
    output logic                   full
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge tx_clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Byte queue and dispatcher feeding the UART transmitter.
//                Define UART_TXQ_STATS_EN to build the sent/timeout counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                   tx_clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   flush,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic [ADDR_W:0]        count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic [15:0]            sent_cnt,
    output logic [15:0]            timeout_cnt
);

    localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    txq_state_e             state_q, state_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   overflow_q, overflow_d;
    logic                   push, pop, ack_expired;
    logic [UART_DATA_W-1:0] fifo_rd_data;

    assign wr_ready    = !full && !flush;
    assign push        = wr_valid && wr_ready;
    assign ack_expired = (state_q == ST_ACK) && !tx_busy && (tmo_q == TMO_LAST);

    uart_txq_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .tx_clk  (tx_clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Flush wins over a dispatch on the same edge.
                if (!empty && !tx_busy && !flush) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_rd_data;
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (tx_busy)          state_d = ST_DONE;
                else if (ack_expired) state_d = ST_IDLE;
                else                  tmo_d   = tmo_q + TMO_ONE;
            end
            ST_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        overflow_d = flush ? 1'b0 : (overflow_q || (wr_valid && !wr_ready));
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign overflow = overflow_q;

`ifdef UART_TXQ_STATS_EN
    logic [15:0] sent_cnt_q, sent_cnt_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    always_comb begin
        sent_cnt_d    = sent_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        if (pop && sent_cnt_q != 16'hFFFF)            sent_cnt_d    = sent_cnt_q + 16'd1;
        if (ack_expired && timeout_cnt_q != 16'hFFFF) timeout_cnt_d = timeout_cnt_q + 16'd1;
    end

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            sent_cnt_q    <= sent_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign sent_cnt    = sent_cnt_q;
    assign timeout_cnt = timeout_cnt_q;
`else
    assign sent_cnt    = 16'h0000;
    assign timeout_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Directed self-checking bench for uart_tx_queue with a simple
//                transmitter model on tx_busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int ADDR_W      = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int FRAME_LEN   = 4;
`ifdef UART_TXQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              tx_clk   = 1'b0;
    logic              rst_n    = 1'b0;
    logic [7:0]        wr_data  = 8'h00;
    logic              wr_valid = 1'b0;
    logic              flush    = 1'b0;
    logic              tx_busy;
    logic              wr_ready, tx_start, empty, full, overflow;
    logic [7:0]        tx_data;
    logic [ADDR_W:0]   count;
    logic [15:0]       sent_cnt, timeout_cnt;

    int         checks = 0;
    int         failures = 0;
    int         busy_cnt = 0;
    bit         model_ack = 1'b1;
    bit         hold_busy = 1'b0;
    bit         prev_start = 1'b0;
    int         start_pulses = 0;
    int         dbl_starts = 0;
    logic [7:0] got_q [$];
    int         gap, p0;
    bit         found;

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .tx_clk      (tx_clk),
        .rst_n       (rst_n),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .flush       (flush),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .sent_cnt    (sent_cnt),
        .timeout_cnt (timeout_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    // Transmitter model: raises tx_busy for FRAME_LEN cycles after each start,
    // updated on the falling edge so the DUT sees a settled value.
    always @(negedge tx_clk) begin
        if (!rst_n) begin
            busy_cnt   = 0;
            prev_start = 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
            if (tx_start) begin
                start_pulses = start_pulses + 1;
                got_q.push_back(tx_data);
                if (model_ack)  busy_cnt   = FRAME_LEN;
                if (prev_start) dbl_starts = dbl_starts + 1;
            end
            prev_start = tx_start;
        end
        tx_busy = hold_busy || (busy_cnt != 0);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check_val("rst_count",    32'(count), 0);
        check_val("rst_empty",    32'(empty), 1);
        check_val("rst_full",     32'(full), 0);
        check_val("rst_wr_ready", 32'(wr_ready), 1);
        check_val("rst_tx_start", 32'(tx_start), 0);
        check_val("rst_tx_data",  32'(tx_data), 0);
        check_val("rst_overflow", 32'(overflow), 0);
        check_val("rst_sent",     32'(sent_cnt), 0);
        check_val("rst_timeout",  32'(timeout_cnt), 0);

        // 1: single byte, start two edges after the push
        push_byte(8'hA5);
        check_val("t1_count_after_push", 32'(count), 1);
        check_val("t1_no_start_yet",     32'(tx_start), 0);
        tick(1);
        check_val("t1_start",   32'(tx_start), 1);
        check_val("t1_data",    32'(tx_data), 32'h A5);
        check_val("t1_count_0", 32'(count), 0);
        tick(1);
        check_val("t1_start_one_cycle", 32'(tx_start), 0);
        tick(10);

        // 2: fill to 16, overflow on 17th, in-order drain
        hold_busy = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        check_val("t2_full",      32'(full), 1);
        check_val("t2_wr_ready",  32'(wr_ready), 0);
        check_val("t2_count16",   32'(count), 16);
        check_val("t2_no_ovf",    32'(overflow), 0);
        push_byte(8'hEE);
        check_val("t2_overflow",  32'(overflow), 1);
        check_val("t2_count_kept", 32'(count), 16);
        got_q.delete();
        hold_busy = 1'b0;
        for (int k = 0; k < 200 && got_q.size() < 16; k++) tick(1);
        check_val("t2_nbytes", got_q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < got_q.size()) check_val($sformatf("t2_byte%0d", i), 32'(got_q[i]), i);
        tick(8);
        check_val("t2_sent_cnt", 32'(sent_cnt), STATS ? 17 : 0);

        // 3: transmitter never acknowledges
        model_ack = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        check_val("t3_start1", 32'(tx_start), 1);
        check_val("t3_data1",  32'(tx_data), 32'h11);
        gap = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (tx_start && gap == 0) begin
                gap = k;
                check_val("t3_data2",   32'(tx_data), 32'h22);
                check_val("t3_timeout", 32'(timeout_cnt), STATS ? 1 : 0);
            end
        end
        check_val("t3_gap", gap, ACK_TIMEOUT + 1);
        tick(12);
        model_ack = 1'b1;
        tick(2);

        // 4: flush while byte 0 is in DONE with 4 bytes behind it
        hold_busy = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
        check_val("t4_count5", 32'(count), 5);
        hold_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            tick(1);
            if (tx_start) found = 1'b1;
        end
        check_val("t4_dispatched", 32'(found), 1);
        check_val("t4_data",       32'(tx_data), 32'h30);
        check_val("t4_count4",     32'(count), 4);
        tick(1);
        check_val("t4_ovf_sticky", 32'(overflow), 1);
        flush = 1'b1;
        #1;
        check_val("t4_wr_ready_flush", 32'(wr_ready), 0);
        tick(1);
        flush = 1'b0;
        check_val("t4_count0",   32'(count), 0);
        check_val("t4_empty",    32'(empty), 1);
        check_val("t4_ovf_clr",  32'(overflow), 0);
        check_val("t4_data_held", 32'(tx_data), 32'h30);
        p0 = start_pulses;
        tick(15);
        check_val("t4_no_start", start_pulses - p0, 0);
        check_val("t4_busy_fell", 32'(tx_busy), 0);

        // 5: advance pointers to 10, then push+pop at level 5 across the wrap
        hold_busy = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) push_byte(8'h60 + 8'(i));
        p0 = start_pulses;
        hold_busy = 1'b0;
        for (int k = 0; k < 120 && (start_pulses - p0) < 10; k++) tick(1);
        check_val("t5_drained", start_pulses - p0, 10);
        tick(8);
        check_val("t5_empty", 32'(empty), 1);
        hold_busy = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
        check_val("t5_count5", 32'(count), 5);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                tick(8);
                hold_busy = 1'b0;
                tick(1);
            end else begin
                hold_busy = 1'b0;
            end
            wr_data  = 8'h55 + 8'(i);
            wr_valid = 1'b1;
            tick(1);
            wr_valid  = 1'b0;
            hold_busy = 1'b1;
            check_val($sformatf("t5_count_i%0d", i), 32'(count), 5);
            check_val($sformatf("t5_start_i%0d", i), 32'(tx_start), 1);
            check_val($sformatf("t5_data_i%0d", i),  32'(tx_data), 32'h50 + i);
        end

        // 6: asynchronous reset while in DONE with 3 bytes queued
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
        check_val("t6_count3", 32'(count), 3);
        #2;
        rst_n     = 1'b0;
        hold_busy = 1'b0;
        #1;
        check_val("t6_rst_start", 32'(tx_start), 0);
        check_val("t6_rst_count", 32'(count), 0);
        check_val("t6_rst_empty", 32'(empty), 1);
        tick(2);
        rst_n = 1'b1;
        p0 = start_pulses;
        tick(20);
        check_val("t6_no_stale_start", start_pulses - p0, 0);
        check_val("t6_count_after",    32'(count), 0);
        check_val("t6_sent_after",     32'(sent_cnt), 0);
        check_val("t6_timeout_after",  32'(timeout_cnt), 0);

        check_val("start_single_cycle", dbl_starts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
